// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned fetches to instruction memory and
// buffers {pc, instr} pairs in a small circular queue in front of decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [3:0]  fifo_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   stale_addr_q, stale_addr_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic req_int;
  logic push;
  logic pop;
  logic unused_redirect_low;

  assign unused_redirect_low = ^redirect_pc[1:0];

  // An issued-but-unacked request keeps imem_req high even across a redirect.
  always_comb begin
    req_int = 1'b1;
    if (state_q == ST_FETCH) begin
      req_int = pending_q | ((count_q < DEPTH_C) & ~redirect);
    end
  end

  assign imem_req    = req_int & ~reset;
  assign imem_addr   = (state_q == ST_DISCARD) ? stale_addr_q : pc_q;
  assign push        = (state_q == ST_FETCH) & req_int & imem_ack & ~redirect;
  assign pop         = (count_q != 4'd0) & dec_ready & ~redirect;
  assign instr_valid = (count_q != 4'd0);
  assign instr_out   = instr_valid ? instr_mem_q[head_q] : 32'h0;
  assign pc_out      = instr_valid ? pc_mem_q[head_q] : 32'h0;
  assign fifo_count  = count_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pc_mem_d     = pc_mem_q;
    instr_mem_d  = instr_mem_q;

    if (redirect) begin
      count_d = 4'd0;
      head_d  = '0;
      tail_d  = '0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      // A request still in flight must be waited out before the new target is fetched.
      if ((state_q == ST_FETCH) && pending_q && !imem_ack) begin
        state_d      = ST_DISCARD;
        stale_addr_d = pc_q;
      end else if ((state_q == ST_DISCARD) && imem_ack) begin
        state_d = ST_FETCH;
      end
    end else begin
      if ((state_q == ST_DISCARD) && imem_ack) begin
        state_d = ST_FETCH;
      end
      if (push) begin
        pc_mem_d[tail_q]    = pc_q;
        instr_mem_d[tail_q] = imem_rdata;
        tail_d              = tail_q + 1'b1;
        pc_d                = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + 4'(push) - 4'(pop);
    end

    pending_d = (state_d == ST_FETCH) & req_int & ~imem_ack & ~redirect;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= 32'h0;
      pending_q    <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 4'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= 32'h0;
        instr_mem_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      pending_q    <= pending_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_mem_q     <= pc_mem_d;
      instr_mem_q  <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, wrap and async reset.
// The memory model acks only while imem_req is high and returns the inverted address as data.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [3:0]  fifo_count;

  int checks = 0;
  int passes = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs starting just after a rising edge; returns at edge+3ns.
  task automatic applyStimulus(input logic ack_en, input logic dec, input logic redir,
                               input logic [31:0] rpc);
    redirect    = redir;
    redirect_pc = rpc;
    dec_ready   = dec;
    #1;
    imem_ack   = ack_en & imem_req;
    imem_rdata = ~imem_addr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    dec_ready   = 1'b0;
    #2;
    checkOutput("rst_req",   32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_pcout", pc_out, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Stream: ack every cycle, decode always ready
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("first_req",   32'(imem_req), 32'd1);
    checkOutput("first_addr",  imem_addr, 32'h0);
    checkOutput("first_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      e = 32'(4 * (k - 1));
      checkOutput("stream_pc",    pc_out, e);
      checkOutput("stream_instr", instr_out, ~e);
      checkOutput("stream_addr",  imem_addr, e + 32'd4);
      checkOutput("stream_count", 32'(fifo_count), 32'd1);
      tick();
    end

    // Backpressure: head stays at 24, queue fills to 4, request drops
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("bp_count", 32'(fifo_count), (i < 4) ? 32'(i) : 32'd4);
      checkOutput("bp_req",   32'(imem_req), (i < 4) ? 32'd1 : 32'd0);
      checkOutput("bp_head",  pc_out, 32'd24);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      e = 32'(24 + 4 * i);
      checkOutput("drain_pc",    pc_out, e);
      checkOutput("drain_instr", instr_out, ~e);
      checkOutput("drain_count", 32'(fifo_count), (i == 0) ? 32'd4 : 32'd3);
      tick();
    end

    // Refill to full, then redirect to an unaligned target
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fill_addr", imem_addr, 32'd56);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    checkOutput("redir_full_req", 32'(imem_req), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_count", 32'(fifo_count), 32'd0);
    checkOutput("redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir_addr",  imem_addr, 32'h0000_0100);
    checkOutput("redir_instr", instr_out, 32'h0);
    checkOutput("redir_pcout", pc_out, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0020);
    checkOutput("lat_pc",    pc_out, 32'h0000_0100);
    checkOutput("lat_instr", instr_out, ~32'h0000_0100);
    checkOutput("lat_req",   32'(imem_req), 32'd0);
    tick();

    // Redirect while a request at 0x20 stalls; a second redirect in DISCARD wins
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("stall1_addr",  imem_addr, 32'h20);
    checkOutput("stall1_count", 32'(fifo_count), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0080);
    checkOutput("stall2_req",  32'(imem_req), 32'd1);
    checkOutput("stall2_addr", imem_addr, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0091);
    checkOutput("disc1_req",  32'(imem_req), 32'd1);
    checkOutput("disc1_addr", imem_addr, 32'h20);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("disc2_addr", imem_addr, 32'h20);
    checkOutput("disc2_ack",  32'(imem_ack), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("post_disc_count", 32'(fifo_count), 32'd0);
    checkOutput("post_disc_addr",  imem_addr, 32'h90);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_disc_head",  pc_out, 32'h90);
    checkOutput("post_disc_instr", instr_out, ~32'h90);
    checkOutput("post_disc_next",  imem_addr, 32'h94);
    tick();

    // Redirect coinciding with ack: data dropped, no DISCARD
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0202);
    checkOutput("coinc_req",  32'(imem_req), 32'd1);
    checkOutput("coinc_addr", imem_addr, 32'h94);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("coinc_count", 32'(fifo_count), 32'd0);
    checkOutput("coinc_next",  imem_addr, 32'h200);
    tick();

    // Wrap at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_next",  imem_addr, 32'h0);
    checkOutput("wrap_head",  pc_out, 32'hFFFF_FFFC);
    checkOutput("wrap_instr", instr_out, 32'h3);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();

    // Async reset between edges with a request pending
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd2);
    checkOutput("pre_rst_addr",  imem_addr, 32'h4);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst_req",   32'(imem_req), 32'd0);
    checkOutput("arst_count", 32'(fifo_count), 32'd0);
    checkOutput("arst_valid", 32'(instr_valid), 32'd0);
    checkOutput("arst_instr", instr_out, 32'h0);
    checkOutput("arst_pcout", pc_out, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rel_req",   32'(imem_req), 32'd1);
    checkOutput("rel_addr",  imem_addr, 32'h0);
    checkOutput("rel_count", 32'(fifo_count), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rel_head",  pc_out, 32'h0);
    checkOutput("rel_instr", instr_out, 32'hFFFF_FFFF);
    checkOutput("rel_cnt1",  32'(fifo_count), 32'd1);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the instruction queue entries; legal values are powers of two from 2 to 8.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction memory request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 The block SHALL have port imem_ack, input, 1 bit: memory accepts the request; imem_rdata is valid in the same cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: the fetched instruction word.
REQ-009 The block SHALL have port redirect, input, 1 bit: jump taken, flush and refetch.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: the jump target.
REQ-011 The block SHALL have port dec_ready, input, 1 bit: the decode latch enable; it consumes the head entry.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: the queue head is valid.
REQ-013 The block SHALL have port instr_out, output, 32 bits: the head instruction.
REQ-014 The block SHALL have port pc_out, output, 32 bits: the head instruction address.
REQ-015 The block SHALL have port fifo_count, output, 4 bits: the number of occupied entries.

Function
REQ-016 The FSM SHALL have two states: FETCH (normal) and DISCARD (wait out a stale request).
REQ-017 In FETCH, imem_req SHALL be 1 when fifo_count < DEPTH and redirect = 0. imem_addr SHALL equal the internal pc.
REQ-018 Once imem_req is asserted, imem_req and imem_addr SHALL hold stable until imem_ack, except as REQ-023 allows.
REQ-019 On imem_req & imem_ack in FETCH with no redirect, the block SHALL push {pc, imem_rdata} at the tail and set pc <= pc + 4, wrapping mod 2^32.
REQ-020 A pop SHALL occur when instr_valid & dec_ready & !redirect; the head then advances one entry.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged. The queue SHALL never exceed DEPTH entries and SHALL never underflow.
REQ-022 instr_valid SHALL equal (fifo_count != 0). When the queue is empty, instr_out and pc_out SHALL be 0.
REQ-023 On redirect, all of the following SHALL take effect at the next edge:
- the queue is flushed (fifo_count = 0);
- any push or pop in that cycle is suppressed;
- pc <= {redirect_pc[31:2], 2'b00}.
REQ-024 If redirect arrives while imem_req = 1 and imem_ack = 0, the FSM SHALL enter DISCARD and keep the old imem_addr with imem_req = 1 until imem_ack. The response data SHALL be dropped and the FSM SHALL return to FETCH.
REQ-025 If redirect and imem_ack coincide, the acknowledged data SHALL be dropped and the FSM SHALL stay in FETCH.
REQ-026 A further redirect in DISCARD SHALL overwrite the target pc. The last redirect SHALL win.
REQ-027 No push SHALL occur in DISCARD. Pops SHALL not occur because the queue is empty.
REQ-028 Fetch-to-decode latency SHALL be 1 cycle: data acknowledged in cycle N appears at the head in cycle N+1 if the queue was empty.

Reset
REQ-029 While reset = 1, the block SHALL hold: pc = RESET_PC, FSM = FETCH, fifo_count = 0, instr_valid = 0, imem_req = 0, instr_out = 0, pc_out = 0. Outputs SHALL clear asynchronously.
REQ-030 The first imem_req SHALL assert in the first clock cycle after reset deasserts, with imem_addr = RESET_PC.
REQ-031 A reset mid-request or in DISCARD SHALL abandon the transaction. No data from before the reset SHALL reach the queue.

Verification
REQ-032 Stream test: memory acks every cycle and dec_ready = 1. Required: instr_out/pc_out pairs appear in order, pc_out = 0, 4, 8, ..., one per cycle after 1-cycle latency.
REQ-033 Backpressure test: dec_ready = 0 for 10 cycles. Required: fifo_count saturates at 4, imem_req drops to 0, and no entries are lost or duplicated after dec_ready returns to 1.
REQ-034 Redirect with queue full: redirect = 1, redirect_pc = 32'h0000_0103. Required next cycle: fifo_count = 0, instr_valid = 0, imem_addr = 32'h0000_0100.
REQ-035 Redirect while a request is pending: redirect at pc = 0x20 with memory stalling 3 cycles, target 0x80. Required: imem_addr stays 0x20 until ack, that data is dropped, and the next request uses 0x80.
REQ-036 Async reset mid-stream: reset pulses between clock edges. Required: outputs are 0 immediately, and the first request after release is at RESET_PC.
REQ-037 Wrap test: pc = 32'hFFFF_FFFC is fetched. Required: the next imem_addr is 32'h0000_0000.
